// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and defaults for the RV32M multiply/divide unit.
// Holds the funct3 op encoding, the control FSM states, the default widths
// and a small helper that decodes operand signedness from the op.
package muldiv_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } muldiv_state_e;

    // Operand A is signed for every op except the fully unsigned ones.
    function automatic logic opSignedA(input muldiv_op_e op);
        return !(op == OP_MULHU || op == OP_DIVU || op == OP_REMU);
    endfunction

    // Operand B is additionally unsigned for MULHSU.
    function automatic logic opSignedB(input muldiv_op_e op);
        return opSignedA(op) && (op != OP_MULHSU);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: per-iteration datapath of the iterative multiply/divide unit.
// Multiply uses shift-add into a {accHi, accLo} 2*XLEN accumulator, with the
// multiplier shifting out of accLo. Divide is restoring division with the
// partial remainder in accHi and the dividend/quotient shifting through accLo.
// Operands arrive already reduced to magnitudes; sign handling is upstream.
module muldiv_core #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            Load,
    input  logic            Step,
    input  logic            DivMode,
    input  logic [XLEN-1:0] MagA,
    input  logic [XLEN-1:0] MagB,
    output logic [XLEN-1:0] AccHi,
    output logic [XLEN-1:0] AccLo
);

    logic [XLEN-1:0] hiReg;
    logic [XLEN-1:0] loReg;
    logic [XLEN-1:0] operandReg;
    logic            divReg;

    logic [XLEN:0]   mulSum;
    logic [XLEN:0]   divShift;
    logic            divFits;
    logic [XLEN-1:0] divDiff;
    logic [XLEN-1:0] hiNext;
    logic [XLEN-1:0] loNext;

    // One iteration of either shift-add multiply or restoring divide.
    always_comb begin
        hiNext   = hiReg;
        loNext   = loReg;
        mulSum   = {1'b0, hiReg} + (loReg[0] ? {1'b0, operandReg} : '0);
        divShift = {hiReg, loReg[XLEN-1]};
        divFits  = (divShift >= {1'b0, operandReg});
        divDiff  = divShift[XLEN-1:0] - operandReg;
        if (divReg) begin
            hiNext = divFits ? divDiff : divShift[XLEN-1:0];
            loNext = {loReg[XLEN-2:0], divFits};
        end else begin
            hiNext = mulSum[XLEN:1];
            loNext = {mulSum[0], loReg[XLEN-1:1]};
        end
    end

    // Accumulator registers: load operands on capture, then iterate.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hiReg      <= '0;
            loReg      <= '0;
            operandReg <= '0;
            divReg     <= 1'b0;
        end else if (Load) begin
            divReg     <= DivMode;
            hiReg      <= '0;
            loReg      <= DivMode ? MagA : MagB;
            operandReg <= DivMode ? MagB : MagA;
        end else if (Step) begin
            hiReg <= hiNext;
            loReg <= loNext;
        end
    end

    assign AccHi = hiReg;
    assign AccLo = loReg;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with register-file
// write-back outputs. Captures operands as magnitudes plus sign flags, runs
// XLEN iterations in muldiv_core, then applies sign fix-up and selects the
// result word. Divide-by-zero and signed overflow are detected at capture.
// Build option: MULDIV_FAST_SPECIAL_EN sends those special cases straight
// from IDLE to DONE; without it they take the full iterative path.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              Start,
    input  logic [2:0]        Op,
    input  logic [XLEN-1:0]   OperandA,
    input  logic [XLEN-1:0]   OperandB,
    input  logic [REG_AW-1:0] DestReg,
    output logic              Busy,
    output logic              Done,
    output logic [REG_AW-1:0] WriteReg,
    output logic [XLEN-1:0]   WriteData,
    output logic              RegWrite
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e state;
    muldiv_state_e stateNext;

    muldiv_op_e      opIn;
    logic            signAIn;
    logic            signBIn;
    logic [XLEN-1:0] magAIn;
    logic [XLEN-1:0] magBIn;
    logic            divZeroIn;
    logic            overflowIn;
    logic            specialIn;
    logic [XLEN-1:0] specialResultIn;

    muldiv_op_e        opReg;
    logic [REG_AW-1:0] rdReg;
    logic              signAReg;
    logic              signBReg;
    logic              specialReg;
    logic [XLEN-1:0]   specialResultReg;
    logic [CW-1:0]     counter;

    logic captureEn;
    logic fastEn;
    logic fixEn;

    logic [XLEN-1:0]   accHi;
    logic [XLEN-1:0]   accLo;
    logic [2*XLEN-1:0] productFix;
    logic [XLEN-1:0]   quotientFix;
    logic [XLEN-1:0]   remainderFix;
    logic [XLEN-1:0]   fixResult;

    // Decode the incoming request: signs, magnitudes and special cases.
    always_comb begin
        opIn       = muldiv_op_e'(Op);
        signAIn    = opSignedA(opIn) && OperandA[XLEN-1];
        signBIn    = opSignedB(opIn) && OperandB[XLEN-1];
        magAIn     = signAIn ? -OperandA : OperandA;
        magBIn     = signBIn ? -OperandB : OperandB;
        divZeroIn  = Op[2] && (OperandB == '0);
        overflowIn = Op[2] && !Op[0] && (OperandA == SIGNED_MIN) && (OperandB == '1);
        specialIn  = divZeroIn || overflowIn;
        if (divZeroIn) begin
            specialResultIn = Op[1] ? OperandA : '1;
        end else begin
            specialResultIn = Op[1] ? '0 : SIGNED_MIN;
        end
    end

    // Control FSM state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Control FSM next-state and datapath strobes.
    always_comb begin
        stateNext = state;
        captureEn = 1'b0;
        fastEn    = 1'b0;
        fixEn     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Start) begin
                    captureEn = 1'b1;
`ifdef MULDIV_FAST_SPECIAL_EN
                    if (specialIn) begin
                        fastEn    = 1'b1;
                        stateNext = ST_DONE;
                    end else begin
                        stateNext = ST_CALC;
                    end
`else
                    stateNext = ST_CALC;
`endif
                end
            end
            ST_CALC: begin
                if (counter == CW'(1)) begin
                    stateNext = ST_FIX;
                end
            end
            ST_FIX: begin
                fixEn     = 1'b1;
                stateNext = ST_DONE;
            end
            ST_DONE: begin
                stateNext = ST_IDLE;
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    // Capture registers and iteration counter.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            opReg            <= OP_MUL;
            rdReg            <= '0;
            signAReg         <= 1'b0;
            signBReg         <= 1'b0;
            specialReg       <= 1'b0;
            specialResultReg <= '0;
            counter          <= '0;
        end else if (captureEn) begin
            opReg            <= opIn;
            rdReg            <= DestReg;
            signAReg         <= signAIn;
            signBReg         <= signBIn;
            specialReg       <= specialIn;
            specialResultReg <= specialResultIn;
            counter          <= CW'(XLEN);
        end else if (state == ST_CALC) begin
            counter <= counter - CW'(1);
        end
    end

    muldiv_core #(
        .XLEN (XLEN)
    ) u_core (
        .CLK     (CLK),
        .RESET   (RESET),
        .Load    (captureEn),
        .Step    (state == ST_CALC),
        .DivMode (Op[2]),
        .MagA    (magAIn),
        .MagB    (magBIn),
        .AccHi   (accHi),
        .AccLo   (accLo)
    );

    // Sign fix-up and result word selection.
    always_comb begin
        productFix   = (signAReg ^ signBReg) ? -{accHi, accLo} : {accHi, accLo};
        quotientFix  = (signAReg ^ signBReg) ? -accLo : accLo;
        remainderFix = signAReg ? -accHi : accHi;
        case (opReg)
            OP_MUL:                        fixResult = productFix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fixResult = productFix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fixResult = quotientFix;
            default:                       fixResult = remainderFix;
        endcase
        if (specialReg) begin
            fixResult = specialResultReg;
        end
    end

    // Write-back registers, held between completions.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            WriteData <= '0;
            WriteReg  <= '0;
        end else if (fastEn) begin
            WriteData <= specialResultIn;
            WriteReg  <= DestReg;
        end else if (fixEn) begin
            WriteData <= fixResult;
            WriteReg  <= rdReg;
        end
    end

    assign Busy     = (state != ST_IDLE);
    assign Done     = (state == ST_DONE);
    assign RegWrite = Done && (WriteReg != '0);

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit for the multi-cycle execute path. It consumes the two operands delivered by the register-file read ports and produces a write-back triple (WriteReg, WriteData, RegWrite) that drives the register-file write port directly. A shift-add/restoring datapath handles one operation at a time: 32 iterations, then sign fix-up.

## Interface
- XLEN, 32, operand/result width; iteration count equals XLEN
- REG_AW, 5, destination register index width
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- Start  in  1  request; accepted only when Busy=0
- Op  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- OperandA  in  XLEN  rs1 value (dividend / multiplicand)
- OperandB  in  XLEN  rs2 value (divisor / multiplier)
- DestReg  in  REG_AW  rd index
- Busy  out  1  high whenever state ≠ IDLE
- Done  out  1  one-cycle completion pulse
- WriteReg  out  REG_AW  captured rd; valid with Done
- WriteData  out  XLEN  result; valid with Done, held until next Done
- RegWrite  out  1  Done && (WriteReg ≠ 0)

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE, Start=1: capture Op, DestReg, |A|, |B|, and the sign flags. Signedness per Op: MULHSU treats A as signed and B as unsigned. MULHU/DIVU/REMU are unsigned. The rest are signed. Load the iteration counter with XLEN and go to CALC.
- CALC:
  - Multiply: one shift-add step per cycle into a 2·XLEN accumulator.
  - Divide: one restoring step per cycle, producing quotient and remainder.
  - The counter decrements each cycle. At 0, go to FIX.
- FIX: apply sign correction.
  - Product is negated when sA^sB.
  - Quotient is negated when sA^sB.
  - Remainder is negated when sA.
  - Select the result: low word for MUL; high word for MULH*; quotient for DIV/DIVU; remainder for REM/REMU.
  - Go to DONE.
- DONE: Done=1 and RegWrite per rule above, then IDLE. Start in DONE is ignored.
- Start while Busy is ignored; inputs are not re-sampled.
- Division by zero: quotient = all ones, remainder = dividend.
- Signed overflow (0x80000000 / −1): quotient = 0x80000000, remainder = 0.
- Special cases are detected at capture.
- All arithmetic is modulo 2^XLEN. Negation is two's complement on the full accumulator width.

## Timing
- Start accepted at edge t → Busy high in cycles t+1..t+34. Done/RegWrite are high in cycle t+34 only, and Busy=0 from t+35.
- The earliest next accept is edge t+35; back-to-back throughput is 1 op / 35 cycles.
- Reset values: Busy=0, Done=0, RegWrite=0, WriteReg=0, WriteData=0; state IDLE, counter 0.
- RESET mid-operation: next cycle is IDLE, no Done/RegWrite is ever produced for the aborted op, and the unit is ready for Start the cycle after RESET falls.
- RESET and Start in the same cycle: RESET wins and the request is dropped.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- MULDIV_FAST_SPECIAL_EN defined:
  - Divide-by-zero and signed-overflow requests go IDLE→DONE directly: Done at t+1, Busy high only in t+1.
  - Normal ops are unchanged.
- MULDIV_FAST_SPECIAL_EN undefined:
  - Special cases run the full CALC/FIX sequence with latency t+34.
  - The result values are identical to the defined case.

## Structure
- muldiv_pkg holds the op enum (funct3 values), the state enum, and the XLEN/REG_AW defaults.
- Sub-module muldiv_core holds the per-iteration shift-add/restoring datapath and accumulator registers; the FSM, capture logic, and fix-up stay in muldiv_unit.

## Test plan
- MUL 7 × 0xFFFFFFFD, rd=5 → WriteData 0xFFFFFFEB, WriteReg 5, RegWrite exactly at t+34.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD. REM 0xFFFFFFF9/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Special cases:
  - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
  - Done at t+1 with MULDIV_FAST_SPECIAL_EN, t+34 without.
- Mid-operation control:
  - Start pulsed at t+5 while busy → ignored, single Done at t+34.
  - RESET at t+10 → Busy 0 at t+11, no Done, next Start accepted normally.
- rd=0 MUL 3×4 → Done=1, RegWrite=0, WriteData 12.
